// File: rtl/adsr_env_gen.sv
// ADSR envelope generator: attack/decay/sustain/release with live sustain tracking and legato retrigger.
// Optional hold stage between attack and decay is enabled by defining ADSR_HOLD_EN.
module adsr_env_gen #(
  parameter int WIDTH       = 8,
  parameter bit RETRIG_ZERO = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             gate_i,
  input  logic [WIDTH-1:0] ai_i,
  input  logic [WIDTH-1:0] di_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] ri_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] envelope_o,
  output logic [2:0]       state_o,
  output logic             active_o,
  output logic             done_o
);

  // state | meaning
  // IDLE  | silent, waiting for gate
  // ATT   | ramping up by ai towards MAX
  // DEC   | ramping down by di towards s
  // SUS   | following s while gate held
  // REL   | ramping down by ri towards 0
  // HOLD  | parked at MAX for hi+1 ticks (ADSR_HOLD_EN only)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ATT  = 3'd1,
    ST_DEC  = 3'd2,
    ST_SUS  = 3'd3,
    ST_REL  = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  localparam logic [WIDTH-1:0] ENV_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   ENV_MAX_X = {1'b0, ENV_MAX};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] env_q, env_d;
  logic             active_q, done_q, done_d;
  logic [WIDTH:0]   sum_x, diff_x;

`ifdef ADSR_HOLD_EN
  logic [WIDTH-1:0] hold_q, hold_d;
`else
  logic unused_hi;
  assign unused_hi = ^hi_i;
`endif

  // One extra bit keeps overflow/underflow visible before clamping.
  assign sum_x  = {1'b0, env_q} + {1'b0, ai_i};
  assign diff_x = {1'b0, env_q} - {1'b0, di_i};

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    done_d  = 1'b0;
`ifdef ADSR_HOLD_EN
    hold_d  = hold_q;
`endif
    if (ce_i) begin
      case (state_q)
        ST_IDLE: begin
          if (gate_i) state_d = ST_ATT;
        end
        ST_ATT: begin
          if (!gate_i) begin
            state_d = ST_REL;
          end else if (sum_x >= ENV_MAX_X) begin
            env_d = ENV_MAX;
`ifdef ADSR_HOLD_EN
            state_d = ST_HOLD;
            hold_d  = '0;
`else
            state_d = ST_DEC;
`endif
          end else begin
            env_d = sum_x[WIDTH-1:0];
          end
        end
        ST_DEC: begin
          if (!gate_i) begin
            state_d = ST_REL;
          end else if (diff_x[WIDTH] || (diff_x[WIDTH-1:0] <= s_i)) begin
            env_d   = s_i;
            state_d = ST_SUS;
          end else begin
            env_d = diff_x[WIDTH-1:0];
          end
        end
        ST_SUS: begin
          if (!gate_i) state_d = ST_REL;
          else         env_d   = s_i;
        end
        ST_REL: begin
          if (gate_i) begin
            state_d = ST_ATT;
            if (RETRIG_ZERO) env_d = '0;
          end else if (env_q <= ri_i) begin
            env_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            env_d = env_q - ri_i;
          end
        end
`ifdef ADSR_HOLD_EN
        ST_HOLD: begin
          if (!gate_i)              state_d = ST_REL;
          else if (hold_q >= hi_i)  state_d = ST_DEC;
          else                      hold_d  = hold_q + 1'b1;
        end
`endif
        default: begin
          state_d = ST_IDLE;
          env_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      env_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADSR_HOLD_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      active_q <= (state_d != ST_IDLE);
      done_q   <= done_d;
`ifdef ADSR_HOLD_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign envelope_o = env_q;
  assign state_o    = state_q;
  assign active_o   = active_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_adsr_env_gen.sv
// Bench for adsr_env_gen: two instances (RETRIG_ZERO=0/1) share stimulus; expected
// outputs are queued per tick and compared after the clock edge.
module tb_adsr_env_gen;

  localparam logic [2:0] S_IDLE = 3'd0, S_A = 3'd1, S_D = 3'd2, S_S = 3'd3, S_R = 3'd4, S_H = 3'd5;
`ifdef ADSR_HOLD_EN
  localparam logic [2:0] AFTER_A = S_H;
`else
  localparam logic [2:0] AFTER_A = S_D;
`endif

  logic       clk, rst_n, ce, gate;
  logic [7:0] ai, di, s, ri, hi;
  logic [7:0] env0, env1;
  logic [2:0] st0, st1;
  logic       act0, act1, dn0, dn1;

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
    logic [2:0] st;
    logic       dn;
    logic       ac;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  adsr_env_gen #(.WIDTH(8), .RETRIG_ZERO(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .gate_i(gate),
    .ai_i(ai), .di_i(di), .s_i(s), .ri_i(ri), .hi_i(hi),
    .envelope_o(env0), .state_o(st0), .active_o(act0), .done_o(dn0)
  );

  adsr_env_gen #(.WIDTH(8), .RETRIG_ZERO(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .gate_i(gate),
    .ai_i(ai), .di_i(di), .s_i(s), .ri_i(ri), .hi_i(hi),
    .envelope_o(env1), .state_o(st1), .active_o(act1), .done_o(dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] e0, input logic [7:0] e1, input logic [2:0] st,
                      input logic dn, input logic ac, input string tag);
    exp_t x;
    x.e0 = e0; x.e1 = e1; x.st = st; x.dn = dn; x.ac = ac; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".env0"}, {24'd0, env0}, {24'd0, x.e0});
      chk({x.tag, ".env1"}, {24'd0, env1}, {24'd0, x.e1});
      chk({x.tag, ".st0"},  {29'd0, st0},  {29'd0, x.st});
      chk({x.tag, ".st1"},  {29'd0, st1},  {29'd0, x.st});
      chk({x.tag, ".done"}, {30'd0, dn0, dn1}, {30'd0, x.dn, x.dn});
      chk({x.tag, ".act"},  {30'd0, act0, act1}, {30'd0, x.ac, x.ac});
    end
  endtask

  // One clock: drive gate/ce, queue the expectation, sample 1 ns after the edge.
  task automatic step(input logic g, input logic c, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [2:0] st, input logic dn, input logic ac, input string tag);
    gate = g;
    ce   = c;
    push(e0, e1, st, dn, ac, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #2;
    push(8'h00, 8'h00, S_IDLE, 1'b0, 1'b0, tag);
    pop_check();
    gate  = 1'b0;
    ce    = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ce = 1'b1; gate = 1'b0;
    ai = 8'h40; di = 8'h20; s = 8'h80; ri = 8'h30; hi = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    push(8'h00, 8'h00, S_IDLE, 1'b0, 1'b0, "reset");
    pop_check();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Attack 0x40 per tick up to MAX
    step(1, 1, 8'h00, 8'h00, S_A, 0, 1, "t1.enterA");
    step(1, 1, 8'h40, 8'h40, S_A, 0, 1, "t1.a40");
    step(1, 1, 8'h80, 8'h80, S_A, 0, 1, "t1.a80");
    step(1, 1, 8'hC0, 8'hC0, S_A, 0, 1, "t1.aC0");
    step(1, 1, 8'hFF, 8'hFF, AFTER_A, 0, 1, "t1.max");
`ifdef ADSR_HOLD_EN
    step(1, 1, 8'hFF, 8'hFF, S_D, 0, 1, "t1.hold0");
`endif
    // Decay to sustain, then live sustain change
    step(1, 1, 8'hDF, 8'hDF, S_D, 0, 1, "t2.dDF");
    step(1, 1, 8'hBF, 8'hBF, S_D, 0, 1, "t2.dBF");
    step(1, 1, 8'h9F, 8'h9F, S_D, 0, 1, "t2.d9F");
    step(1, 1, 8'h80, 8'h80, S_S, 0, 1, "t2.sus80");
    s = 8'h90;
    step(1, 1, 8'h90, 8'h90, S_S, 0, 1, "t2.sus90");
    // Release to idle with done pulse
    step(0, 1, 8'h90, 8'h90, S_R, 0, 1, "t3.enterR");
    step(0, 1, 8'h60, 8'h60, S_R, 0, 1, "t3.r60");
    step(0, 1, 8'h30, 8'h30, S_R, 0, 1, "t3.r30");
    step(0, 1, 8'h00, 8'h00, S_IDLE, 1, 0, "t3.idle");
    step(0, 1, 8'h00, 8'h00, S_IDLE, 0, 0, "t3.donegone");

    // Climb again, settle at 0x90, release to 0x60, then legato retrigger
    step(1, 1, 8'h00, 8'h00, S_A, 0, 1, "t4.enterA");
    step(1, 1, 8'h40, 8'h40, S_A, 0, 1, "t4.a40");
    step(1, 1, 8'h80, 8'h80, S_A, 0, 1, "t4.a80");
    step(1, 1, 8'hC0, 8'hC0, S_A, 0, 1, "t4.aC0");
    step(1, 1, 8'hFF, 8'hFF, AFTER_A, 0, 1, "t4.max");
`ifdef ADSR_HOLD_EN
    step(1, 1, 8'hFF, 8'hFF, S_D, 0, 1, "t4.hold0");
`endif
    step(1, 1, 8'hDF, 8'hDF, S_D, 0, 1, "t4.dDF");
    step(1, 1, 8'hBF, 8'hBF, S_D, 0, 1, "t4.dBF");
    step(1, 1, 8'h9F, 8'h9F, S_D, 0, 1, "t4.d9F");
    step(1, 1, 8'h90, 8'h90, S_S, 0, 1, "t4.sus90");
    step(0, 1, 8'h90, 8'h90, S_R, 0, 1, "t4.enterR");
    step(0, 1, 8'h60, 8'h60, S_R, 0, 1, "t4.r60");
    ai = 8'h10;
    step(1, 1, 8'h60, 8'h00, S_A, 0, 1, "t4.retrig");
    step(1, 1, 8'h70, 8'h10, S_A, 0, 1, "t4.retrig_inc");

    // ce 1-in-4: only ce clocks advance
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++)
        step(1, 0, 8'h70 + 8'(r * 16), 8'h10 + 8'(r * 16), S_A, 0, 1, "t5.ce_off");
      step(1, 1, 8'h80 + 8'(r * 16), 8'h20 + 8'(r * 16), S_A, 0, 1, "t5.ce_on");
    end
    ai = 8'h00;
    step(1, 1, 8'h90, 8'h30, S_A, 0, 1, "t5.ai0stall");
    async_reset("t5.async_rst");

    // Gate low wins over attack overflow
    ai = 8'hC0;
    step(1, 1, 8'h00, 8'h00, S_A, 0, 1, "t7.enterA");
    step(1, 1, 8'hC0, 8'hC0, S_A, 0, 1, "t7.aC0");
    step(0, 1, 8'hC0, 8'hC0, S_R, 0, 1, "t7.gate_prio_A");
    ai = 8'h10;
    step(1, 1, 8'hC0, 8'h00, S_A, 0, 1, "t7.retrig");
    step(1, 1, 8'hD0, 8'h10, S_A, 0, 1, "t7.aD0");
    step(0, 1, 8'hD0, 8'h10, S_R, 0, 1, "t7.enterR");
    ri = 8'hFF;
    step(0, 1, 8'h00, 8'h00, S_IDLE, 1, 0, "t7.r_to_idle");

    // Gate low wins over decay underflow
    ai = 8'hFF; di = 8'hF0; s = 8'h80; ri = 8'h30;
    step(1, 1, 8'h00, 8'h00, S_A, 0, 1, "t8.enterA");
    step(1, 1, 8'hFF, 8'hFF, AFTER_A, 0, 1, "t8.max");
`ifdef ADSR_HOLD_EN
    step(1, 1, 8'hFF, 8'hFF, S_D, 0, 1, "t8.hold0");
`endif
    step(0, 1, 8'hFF, 8'hFF, S_R, 0, 1, "t8.gate_prio_D");
    step(0, 1, 8'hCF, 8'hCF, S_R, 0, 1, "t8.rCF");

`ifdef ADSR_HOLD_EN
    // Hold lasts hi+1 ticks, gate low in hold releases
    async_reset("t6.rst");
    hi = 8'h02;
    step(1, 1, 8'h00, 8'h00, S_A, 0, 1, "t6.enterA");
    step(1, 1, 8'hFF, 8'hFF, S_H, 0, 1, "t6.enterH");
    step(1, 1, 8'hFF, 8'hFF, S_H, 0, 1, "t6.h1");
    step(1, 1, 8'hFF, 8'hFF, S_H, 0, 1, "t6.h2");
    step(1, 1, 8'hFF, 8'hFF, S_D, 0, 1, "t6.toD");
    async_reset("t6.rst2");
    step(1, 1, 8'h00, 8'h00, S_A, 0, 1, "t6.enterA2");
    step(1, 1, 8'hFF, 8'hFF, S_H, 0, 1, "t6.enterH2");
    step(0, 1, 8'hFF, 8'hFF, S_R, 0, 1, "t6.h_release");
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
